// File: rtl/game_pkg.sv
// Shared types and width helpers for the game sequencer and its tick scheduler.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUN       = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_OVER      = 3'd4
    } game_state_e;

    localparam int FAST_FRAME_PERIOD = 21;

    function automatic int winner_width(input int num_players);
        return (num_players > 1) ? $clog2(num_players) : 1;
    endfunction

    function automatic int speed_width(input int speed_levels);
        return (speed_levels > 1) ? $clog2(speed_levels) : 1;
    endfunction

    // Frames-per-tick ranges 1..SPEED_LEVELS, so it needs one value more than the speed.
    function automatic int interval_width(input int speed_levels);
        return $clog2(speed_levels + 1);
    endfunction

endpackage

// File: rtl/tick_sched.sv
// Frame counter, interval compare and per-player pending-tick mask; emits the
// broadcast tick one cycle after the frame that makes it due.
module tick_sched
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int SPEED_LEVELS = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clear,
    input  logic                                     running,
    input  logic                                     tick_allowed,
    input  logic                                     frame,
    input  logic [interval_width(SPEED_LEVELS)-1:0]  interval,
    input  logic [NUM_PLAYERS-1:0]                   alive,
    input  logic [NUM_PLAYERS-1:0]                   tick_done,
    output logic                                     tick
);

    localparam int IW = interval_width(SPEED_LEVELS);

    logic [IW-1:0]          count;
    logic [IW:0]            count_inc;
    logic                   due;
    logic                   reached;
    logic                   fire;
    logic [NUM_PLAYERS-1:0] pending;

    // A tick stays due once reached, so a later slow-down cannot postpone it.
    always_comb begin
        count_inc = {1'b0, count} + (IW + 1)'(1);
        reached   = due || (count_inc >= {1'b0, interval});
        fire      = running && tick_allowed && frame && reached && (pending == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count   <= '0;
            due     <= 1'b0;
            tick    <= 1'b0;
            pending <= '0;
        end else begin
            tick <= fire;
            if (fire) begin
                count   <= '0;
                due     <= 1'b0;
                pending <= alive;
            end else begin
                if (running && frame) begin
                    if (reached) begin
                        count <= interval;
                        due   <= 1'b1;
                    end else begin
                        count <= count_inc[IW-1:0];
                    end
                end
                pending <= pending & alive & ~(tick_done & {NUM_PLAYERS{running}});
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Round state machine, speed select and result logic for a multi-player snake game.
// Define GAME_SEQ_FAST_FRAME_EN to replace i_frame with an internal 21-cycle frame pulse.
module game_sequencer
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS      = 2,
    parameter int SPEED_LEVELS     = 8,
    parameter int COUNTDOWN_FRAMES = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_frame,
    input  logic [NUM_PLAYERS-1:0]                 i_start,
    input  logic                                   i_pause,
    input  logic                                   i_restart,
    input  logic                                   i_speed_up,
    input  logic                                   i_speed_down,
    input  logic [NUM_PLAYERS-1:0]                 i_tick_done,
    input  logic [NUM_PLAYERS-1:0]                 i_failure,
    input  logic [NUM_PLAYERS-1:0]                 i_success,
    output logic [2:0]                             o_state,
    output logic                                   o_tick,
    output logic [NUM_PLAYERS-1:0]                 o_alive,
    output logic [speed_width(SPEED_LEVELS)-1:0]   o_speed,
    output logic [3:0]                             o_countdown,
    output logic [winner_width(NUM_PLAYERS)-1:0]   o_winner,
    output logic                                   o_winner_valid,
    output logic                                   o_failure,
    output logic                                   o_success
);

    localparam int SW = speed_width(SPEED_LEVELS);
    localparam int WW = winner_width(NUM_PLAYERS);
    localparam int IW = interval_width(SPEED_LEVELS);
    localparam logic [SW-1:0] SPEED_MAX = SW'(SPEED_LEVELS - 1);
    localparam logic [3:0]    CD_LOAD   = 4'(COUNTDOWN_FRAMES);

    game_state_e            state_q, state_d;
    logic [NUM_PLAYERS-1:0] alive_d, survivors, winners;
    logic [SW-1:0]          speed_d;
    logic [3:0]             countdown_d;
    logic [WW-1:0]          winner_d;
    logic                   winner_valid_d, failure_d, success_d;
    logic                   frame;

`ifdef GAME_SEQ_FAST_FRAME_EN
    logic [4:0] frame_div;

    always_ff @(posedge clk) begin
        if (rst || frame_div == 5'(FAST_FRAME_PERIOD - 1)) frame_div <= '0;
        else                                               frame_div <= frame_div + 5'd1;
    end

    assign frame = (frame_div == 5'(FAST_FRAME_PERIOD - 1));
`else
    assign frame = i_frame;
`endif

    function automatic logic [WW-1:0] lowest_index(input logic [NUM_PLAYERS-1:0] mask);
        lowest_index = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--)
            if (mask[p]) lowest_index = WW'(p);
    endfunction

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        alive_d        = o_alive;
        speed_d        = o_speed;
        countdown_d    = o_countdown;
        winner_d       = o_winner;
        winner_valid_d = o_winner_valid;
        failure_d      = o_failure;
        success_d      = o_success;
        survivors      = o_alive & ~i_failure;
        winners        = i_success & survivors;

        if (i_speed_up && !i_speed_down && o_speed != SPEED_MAX)
            speed_d = o_speed + SW'(1);
        else if (i_speed_down && !i_speed_up && o_speed != '0)
            speed_d = o_speed - SW'(1);

        case (state_q)
            ST_IDLE: begin
                if (|i_start) begin
                    if (COUNTDOWN_FRAMES == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d     = ST_COUNTDOWN;
                        countdown_d = CD_LOAD;
                    end
                end
            end
            ST_COUNTDOWN: begin
                if (frame) begin
                    countdown_d = o_countdown - 4'd1;
                    if (o_countdown == 4'd1) state_d = ST_RUN;
                end
            end
            ST_RUN, ST_PAUSE: begin
                // Failure wins over a same-player success because winners are drawn from survivors.
                alive_d = survivors;
                if (|winners) begin
                    state_d        = ST_OVER;
                    success_d      = 1'b1;
                    winner_valid_d = 1'b1;
                    winner_d       = lowest_index(winners);
                end else if (survivors == '0) begin
                    state_d   = ST_OVER;
                    failure_d = 1'b1;
                end else if (NUM_PLAYERS > 1 && $countones(survivors) == 1) begin
                    state_d        = ST_OVER;
                    success_d      = 1'b1;
                    winner_valid_d = 1'b1;
                    winner_d       = lowest_index(survivors);
                end else if (state_q == ST_RUN && i_pause) begin
                    state_d = ST_PAUSE;
                end else if (state_q == ST_PAUSE && !i_pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: ;
            default: state_d = ST_IDLE;
        endcase

        if (i_restart) begin
            state_d        = ST_IDLE;
            alive_d        = '1;
            speed_d        = o_speed;
            countdown_d    = '0;
            winner_d       = '0;
            winner_valid_d = 1'b0;
            failure_d      = 1'b0;
            success_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            o_alive        <= '1;
            o_speed        <= '0;
            o_countdown    <= '0;
            o_winner       <= '0;
            o_winner_valid <= 1'b0;
            o_failure      <= 1'b0;
            o_success      <= 1'b0;
        end else begin
            state_q        <= state_d;
            o_alive        <= alive_d;
            o_speed        <= speed_d;
            o_countdown    <= countdown_d;
            o_winner       <= winner_d;
            o_winner_valid <= winner_valid_d;
            o_failure      <= failure_d;
            o_success      <= success_d;
        end
    end

    assign o_state = state_q;

    // Ticks may only fire when the round stays in RUN, so none lands outside it.
    tick_sched #(
        .NUM_PLAYERS  (NUM_PLAYERS),
        .SPEED_LEVELS (SPEED_LEVELS)
    ) u_tick_sched (
        .clk          (clk),
        .rst          (rst),
        .clear        (i_restart),
        .running      (state_q == ST_RUN),
        .tick_allowed (state_d == ST_RUN),
        .frame        (frame),
        .interval     (IW'(SPEED_LEVELS) - IW'(o_speed)),
        .alive        (alive_d),
        .tick_done    (i_tick_done),
        .tick         (o_tick)
    );

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed round scenarios plus a randomized
// RUN phase compared against a frame/acknowledge model of tick pacing and speed.
module tb_game_sequencer;

    localparam int NUM_PLAYERS      = 2;
    localparam int SPEED_LEVELS     = 4;
    localparam int COUNTDOWN_FRAMES = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_frame;
    logic [1:0] i_start;
    logic       i_pause;
    logic       i_restart;
    logic       i_speed_up;
    logic       i_speed_down;
    logic [1:0] i_tick_done;
    logic [1:0] i_failure;
    logic [1:0] i_success;
    logic [2:0] o_state;
    logic       o_tick;
    logic [1:0] o_alive;
    logic [1:0] o_speed;
    logic [3:0] o_countdown;
    logic [0:0] o_winner;
    logic       o_winner_valid;
    logic       o_failure;
    logic       o_success;

    int errors = 0;
    int checks = 0;

    // Reference model: frames since the last tick, whether a tick is overdue,
    // which players still owe an acknowledgement, and the selected speed.
    bit         m_run    = 1'b0;
    bit         m_due    = 1'b0;
    int         m_frames = 0;
    int         m_speed  = 0;
    logic [1:0] m_pend   = 2'b00;
    int         ticks;

    game_sequencer #(
        .NUM_PLAYERS      (NUM_PLAYERS),
        .SPEED_LEVELS     (SPEED_LEVELS),
        .COUNTDOWN_FRAMES (COUNTDOWN_FRAMES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_frame        (i_frame),
        .i_start        (i_start),
        .i_pause        (i_pause),
        .i_restart      (i_restart),
        .i_speed_up     (i_speed_up),
        .i_speed_down   (i_speed_down),
        .i_tick_done    (i_tick_done),
        .i_failure      (i_failure),
        .i_success      (i_success),
        .o_state        (o_state),
        .o_tick         (o_tick),
        .o_alive        (o_alive),
        .o_speed        (o_speed),
        .o_countdown    (o_countdown),
        .o_winner       (o_winner),
        .o_winner_valid (o_winner_valid),
        .o_failure      (o_failure),
        .o_success      (o_success)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: inputs set before the call are sampled at the edge, outputs are
    // checked 1 time unit later, then all pulse inputs are dropped.
    task automatic step();
        bit fire;
        int ivl;
        @(posedge clk);
        #1;
        ivl  = SPEED_LEVELS - m_speed;
        fire = 1'b0;
        if (rst || i_restart) begin
            m_frames = 0;
            m_due    = 1'b0;
            m_pend   = 2'b00;
        end else if (m_run) begin
            if (i_frame) begin
                m_frames++;
                if (m_frames >= ivl) m_due = 1'b1;
                if (m_due && m_pend == 2'b00) fire = 1'b1;
            end
            if (fire) begin
                m_frames = 0;
                m_due    = 1'b0;
                m_pend   = 2'b11;
            end else begin
                m_pend = m_pend & ~i_tick_done;
            end
        end
        if (rst) begin
            m_speed = 0;
        end else if (!i_restart) begin
            if (i_speed_up && !i_speed_down && m_speed < SPEED_LEVELS - 1) m_speed++;
            else if (i_speed_down && !i_speed_up && m_speed > 0)            m_speed--;
        end
        check("tick", {31'd0, o_tick}, {31'd0, fire});
        check("speed", {30'd0, o_speed}, m_speed);
        i_frame      = 1'b0;
        i_start      = 2'b00;
        i_restart    = 1'b0;
        i_speed_up   = 1'b0;
        i_speed_down = 1'b0;
        i_tick_done  = 2'b00;
        i_failure    = 2'b00;
        i_success    = 2'b00;
    endtask

    task automatic start_round();
        i_start = 2'b10;
        step();
        check("round_countdown", {29'd0, o_state}, 1);
        for (int k = 0; k < COUNTDOWN_FRAMES; k++) begin
            i_frame = 1'b1;
            step();
        end
        check("round_run", {29'd0, o_state}, 2);
        m_run = 1'b1;
    endtask

    task automatic restart_round();
        m_run     = 1'b0;
        i_restart = 1'b1;
        step();
        check("restart_state", {29'd0, o_state}, 0);
        check("restart_alive", {30'd0, o_alive}, 2'b11);
        check("restart_valid", {31'd0, o_winner_valid}, 0);
    endtask

    initial begin
        rst = 1'b1;
        i_pause = 1'b0;
        i_frame = 1'b0; i_start = '0; i_restart = 1'b0; i_speed_up = 1'b0; i_speed_down = 1'b0;
        i_tick_done = '0; i_failure = '0; i_success = '0;
        step();
        step();
        check("rst_state", {29'd0, o_state}, 0);
        check("rst_alive", {30'd0, o_alive}, 2'b11);
        check("rst_countdown", {28'd0, o_countdown}, 0);
        check("rst_winner", {31'd0, o_winner}, 0);
        check("rst_results", {29'd0, o_winner_valid, o_failure, o_success}, 0);
        rst = 1'b0;
        step();

        // Start and countdown
        i_start = 2'b01;
        step();
        check("cd_state", {29'd0, o_state}, 1);
        check("cd_load", {28'd0, o_countdown}, 3);
        for (int k = 2; k >= 0; k--) begin
            i_frame = 1'b1;
            step();
            check("cd_value", {28'd0, o_countdown}, k);
            check("cd_phase", {29'd0, o_state}, (k == 0) ? 2 : 1);
        end
        m_run = 1'b1;

        // Tick pacing at speed 0, then after two speed-ups
        ticks = 0;
        for (int k = 0; k < 8; k++) begin
            i_frame = 1'b1;
            step();
            if (o_tick) begin
                ticks++;
                i_tick_done = 2'b11;
            end
            step();
        end
        check("ticks_speed0", ticks, 2);
        i_speed_up = 1'b1; step();
        i_speed_up = 1'b1; step();
        check("speed_two", {30'd0, o_speed}, 2);
        ticks = 0;
        for (int k = 0; k < 4; k++) begin
            i_frame = 1'b1;
            step();
            if (o_tick) begin
                ticks++;
                i_tick_done = 2'b11;
            end
            step();
        end
        check("ticks_speed2", ticks, 2);

        // Backpressure: player 1 withholds its acknowledgement
        i_frame = 1'b1; step();
        i_frame = 1'b1; step();
        check("bp_first_tick", {31'd0, o_tick}, 1);
        i_tick_done = 2'b01;
        step();
        ticks = 0;
        for (int k = 0; k < 6; k++) begin
            i_frame = 1'b1;
            step();
            if (o_tick) ticks++;
            step();
        end
        check("bp_withheld", ticks, 0);
        i_tick_done = 2'b10;
        step();
        i_frame = 1'b1;
        step();
        check("bp_release", {31'd0, o_tick}, 1);
        i_tick_done = 2'b11;
        step();

        // Randomized RUN traffic against the model
        for (int k = 0; k < 400; k++) begin
            i_frame      = ($urandom % 3) == 0;
            i_tick_done  = {($urandom % 4) == 0, ($urandom % 4) == 0};
            i_speed_up   = ($urandom % 16) == 0;
            i_speed_down = ($urandom % 16) == 0;
            step();
        end
        check("rand_state", {29'd0, o_state}, 2);

        // Pause freezes pacing; resume continues under the model
        m_run   = 1'b0;
        i_pause = 1'b1;
        step();
        check("pause_state", {29'd0, o_state}, 3);
        i_frame = 1'b1;
        step();
        i_pause = 1'b0;
        step();
        check("resume_state", {29'd0, o_state}, 2);
        m_run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_frame = 1'b1;
            step();
            i_tick_done = 2'b11;
            step();
        end

        // Elimination leaves a sole survivor
        m_run     = 1'b0;
        i_failure = 2'b10;
        step();
        check("elim_state", {29'd0, o_state}, 4);
        check("elim_alive", {30'd0, o_alive}, 2'b01);
        check("elim_winner", {31'd0, o_winner}, 0);
        check("elim_results", {29'd0, o_winner_valid, o_failure, o_success}, 3'b101);
        for (int k = 0; k < 3; k++) begin
            i_frame   = 1'b1;
            i_failure = 2'b01;
            i_success = 2'b01;
            step();
        end
        check("over_hold_state", {29'd0, o_state}, 4);
        check("over_hold_alive", {30'd0, o_alive}, 2'b01);
        check("over_hold_results", {29'd0, o_winner_valid, o_failure, o_success}, 3'b101);
        restart_round();

        // Simultaneous last deaths
        start_round();
        m_run     = 1'b0;
        i_failure = 2'b11;
        step();
        check("draw_state", {29'd0, o_state}, 4);
        check("draw_alive", {30'd0, o_alive}, 2'b00);
        check("draw_results", {29'd0, o_winner_valid, o_failure, o_success}, 3'b010);
        restart_round();

        // Failure outranks success for the same player
        start_round();
        m_run     = 1'b0;
        i_failure = 2'b01;
        i_success = 2'b01;
        step();
        check("prio_state", {29'd0, o_state}, 4);
        check("prio_alive", {30'd0, o_alive}, 2'b10);
        check("prio_winner", {31'd0, o_winner}, 1);
        check("prio_results", {29'd0, o_winner_valid, o_failure, o_success}, 3'b101);
        restart_round();

        // Simultaneous successes pick the lowest index
        start_round();
        m_run     = 1'b0;
        i_success = 2'b11;
        step();
        check("multi_win_winner", {31'd0, o_winner}, 0);
        check("multi_win_alive", {30'd0, o_alive}, 2'b11);
        check("multi_win_results", {29'd0, o_winner_valid, o_failure, o_success}, 3'b101);
        restart_round();

        // Speed saturation, conflicting pulses, restart in PAUSE, then reset
        start_round();
        for (int k = 0; k < 5; k++) begin
            i_speed_up = 1'b1;
            step();
        end
        check("speed_sat_hi", {30'd0, o_speed}, 3);
        i_speed_up   = 1'b1;
        i_speed_down = 1'b1;
        step();
        check("speed_conflict", {30'd0, o_speed}, 3);
        m_run   = 1'b0;
        i_pause = 1'b1;
        step();
        check("pause2_state", {29'd0, o_state}, 3);
        i_restart = 1'b1;
        step();
        check("pause_restart_state", {29'd0, o_state}, 0);
        check("pause_restart_alive", {30'd0, o_alive}, 2'b11);
        check("pause_restart_speed", {30'd0, o_speed}, 3);
        i_pause = 1'b0;
        rst     = 1'b1;
        step();
        check("rst_speed", {30'd0, o_speed}, 0);
        check("rst_state2", {29'd0, o_state}, 0);
        rst = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            i_speed_down = 1'b1;
            step();
        end
        check("speed_sat_lo", {30'd0, o_speed}, 0);

        // Reset in the middle of a countdown
        i_start = 2'b01;
        step();
        i_frame = 1'b1;
        step();
        check("mid_cd_value", {28'd0, o_countdown}, 2);
        rst = 1'b1;
        step();
        check("mid_cd_rst_value", {28'd0, o_countdown}, 0);
        check("mid_cd_rst_state", {29'd0, o_state}, 0);
        rst = 1'b0;
        step();
        step();
        check("mid_cd_idle", {29'd0, o_state}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of snake channels (1..4).
REQ-002 SHALL have parameter SPEED_LEVELS, default 8, number of selectable tick speeds (2..16).
REQ-003 SHALL have parameter COUNTDOWN_FRAMES, default 3, frames spent in COUNTDOWN (0..15).
REQ-004 SHALL have ports: clk in 1 system clock; rst in 1 reset, synchronous, active-high (one clock; the polarity and synchronicity are fixed).
REQ-005 SHALL have ports: i_frame in 1 one-cycle frame pulse (vsync); i_start in NUM_PLAYERS any direction press per player; i_pause in 1 pause level; i_restart in 1 round restart.
REQ-006 SHALL have ports: i_speed_up, i_speed_down in 1 each, one-cycle pulses; i_tick_done in NUM_PLAYERS per-player tick completion pulse; i_failure, i_success in NUM_PLAYERS each, per-player event pulses.
REQ-007 SHALL have ports: o_state out 3 (IDLE=0, COUNTDOWN=1, RUN=2, PAUSE=3, OVER=4); o_tick out 1 broadcast tick pulse; o_alive out NUM_PLAYERS; o_speed out clog2(SPEED_LEVELS); o_countdown out 4 frames remaining.
REQ-008 SHALL have ports: o_winner out max(1,clog2(NUM_PLAYERS)); o_winner_valid out 1; o_failure out 1 round ended without winner; o_success out 1 round ended with winner.

Function
REQ-009 SHALL transition IDLE->COUNTDOWN on any i_start bit, or IDLE->RUN directly when COUNTDOWN_FRAMES=0.
REQ-010 SHALL load o_countdown=COUNTDOWN_FRAMES on entering COUNTDOWN, decrement on each i_frame, and enter RUN on the i_frame that decrements it from 1 to 0.
REQ-011 SHALL go RUN->PAUSE while i_pause=1 and PAUSE->RUN when i_pause=0; frame counter and pending mask frozen in PAUSE; i_pause ignored in other states.
REQ-012 SHALL set frames-per-tick interval = SPEED_LEVELS - o_speed (slowest at o_speed=0).
REQ-013 SHALL, in RUN, count i_frame pulses; on the i_frame that makes count reach interval with no tick pending, assert o_tick for exactly one cycle (cycle after that i_frame) and clear count.
REQ-014 SHALL load pending mask = o_alive when o_tick asserts; clear bit p on i_tick_done[p] or on player p death; tick pending = OR of mask.
REQ-015 SHALL saturate count at interval while a tick is pending and issue o_tick on the first i_frame after the mask empties.
REQ-016 SHALL increment/decrement o_speed on i_speed_up/i_speed_down in any state, saturating at SPEED_LEVELS-1 and 0; simultaneous up+down SHALL be ignored; new interval applies to the next comparison.
REQ-017 SHALL clear o_alive[p] on i_failure[p] in RUN or PAUSE; events in IDLE, COUNTDOWN, OVER ignored.
REQ-018 SHALL enter OVER with o_success=1, o_winner=p, o_winner_valid=1 when i_success[p] asserts for a live player; multiple same-cycle successes pick lowest index.
REQ-019 SHALL give failure priority when i_failure[p] and i_success[p] assert in the same cycle.
REQ-020 SHALL, for NUM_PLAYERS>1, enter OVER with sole survivor as winner when exactly one player remains alive.
REQ-021 SHALL enter OVER with o_failure=1, o_winner_valid=0 when no player remains alive (including simultaneous last deaths).
REQ-022 SHALL hold OVER and all result outputs until i_restart or rst; no o_tick outside RUN.
REQ-023 SHALL, on i_restart in any state, go to IDLE next cycle: o_alive all ones, pending and counters cleared, results cleared, o_speed retained; i_restart overrides all same-cycle events.

Reset
REQ-024 SHALL on rst: o_state=IDLE, o_tick=0, o_alive all ones, o_speed=0, o_countdown=0, o_winner=0, o_winner_valid=0, o_failure=0, o_success=0, counters and pending mask 0.
REQ-025 SHALL treat rst mid-tick or mid-countdown identically to REQ-024 with no residual pulse.

Configuration
REQ-026 SHALL, with GAME_SEQ_FAST_FRAME_EN defined, ignore i_frame and use an internal frame pulse every 21 cycles (counter cleared by rst); without it, use i_frame exactly.

Structure
REQ-027 SHALL place the state enum and winner/speed width helpers in shared package game_pkg.
REQ-028 SHALL implement frame counting, interval compare and pending mask in sub-module tick_sched; state machine and result logic in game_sequencer.

Verification (NUM_PLAYERS=2, SPEED_LEVELS=4, COUNTDOWN_FRAMES=3)
REQ-029 SHALL test start: i_start=2'b01 in IDLE, then 3 i_frame -> o_countdown 3,2,1,0, o_state=RUN after 3rd frame.
REQ-030 SHALL test ticks: RUN, o_speed=0, i_tick_done both after each tick -> o_tick once per 4 frames; two i_speed_up -> once per 2 frames.
REQ-031 SHALL test backpressure: withhold i_tick_done[1] for 6 frames -> no o_tick; assert it -> o_tick on next frame.
REQ-032 SHALL test elimination: i_failure=2'b10 in RUN -> o_alive=01, OVER, o_winner=0, o_winner_valid=1, o_success=1.
REQ-033 SHALL test draw/priority: i_failure=2'b11 same cycle -> OVER, o_failure=1, o_winner_valid=0; i_failure[0]&i_success[0] -> failure taken.
REQ-034 SHALL test restart: i_restart in PAUSE with o_speed=3 -> IDLE, o_alive=11, o_speed=3; rst -> o_speed=0.
